// File: rtl/timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_if
//
// Bundles the signals between the mm:ss countdown sequencer and the outside
// world: the operator side (digit entry, start/stop strobes, status flags) and
// the four-digit BCD down-counter chain (preset data, load strobe, count
// enable, zero flag).
//
// Signals:
//   digit[3:0]   BCD digit to shift into the preset
//   digit_valid  one-cycle strobe qualifying digit
//   start        one-cycle strobe: start, resume or re-run
//   stop         one-cycle strobe: pause or cancel
//   chain_zero   high when all four chain counters read 0
//   preset[15:0] {min_tens, min_units, sec_tens, sec_units} to the chain
//   load_n       active-low parallel-load strobe to the chain
//   en           count enable to the chain, one-cycle pulse per tick
//   running      controller is counting
//   paused       controller is paused
//   done         countdown reached 00:00
//
// Modports:
//   slave  - the controller (timer_ctrl)
//   master - whatever drives the controller and models the chain
// -----------------------------------------------------------------------------
interface timer_ctrl_if;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        start;
  logic        stop;
  logic        chain_zero;
  logic [15:0] preset;
  logic        load_n;
  logic        en;
  logic        running;
  logic        paused;
  logic        done;

  modport slave (
    input  digit, digit_valid, start, stop, chain_zero,
    output preset, load_n, en, running, paused, done
  );

  modport master (
    output digit, digit_valid, start, stop, chain_zero,
    input  preset, load_n, en, running, paused, done
  );
endinterface

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//
// Sequencing controller for a four-digit mm:ss BCD countdown chain. Collects
// the preset one BCD digit at a time, pulses the chain's active-low load
// strobe, derives the count enable from an internal tick prescaler, and
// handles start / pause / resume / cancel plus completion at 00:00.
//
// Parameters:
//   TICK_DIV  system clocks per timer tick (>= 2)
//
// Ports:
//   clk    system clock, rising edge
//   clear  synchronous active-high reset
//   bus    timer_ctrl_if.slave (digit entry, strobes, chain handshake, status)
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int TICK_DIV = 100
) (
  input  logic          clk,
  input  logic          clear,
  timer_ctrl_if.slave   bus
);

  localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [15:0]    preset_q, preset_d;
  logic           load_n_q, running_q, paused_q, done_q;
  logic           en_c;
  logic           tick;
  logic           preset_ok;

  assign tick = (presc_q == TICK_LAST);

  // A preset is runnable when it is non-zero and the seconds-tens digit is a
  // legal 0..5.
  assign preset_ok = (preset_q != 16'h0000) && (preset_q[7:4] <= 4'd5);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    en_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // stop beats start; a digit arriving with start is discarded and start
        // is judged against the preset as it stands.
        if (bus.start && !bus.stop && preset_ok) begin
          state_d = LOAD;
        end
        if (!bus.start && bus.digit_valid && (bus.digit <= 4'd9)) begin
          preset_d = {preset_q[11:0], bus.digit};
        end
      end

      LOAD: begin
        state_d = RUN;
        presc_d = '0;
      end

      RUN: begin
        if (bus.stop) begin
          // Prescaler held so the partial tick is conserved across the pause.
          state_d = PAUSE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          // Never enable while the chain reads zero, so it cannot wrap to 9.
          en_c    = tick && !bus.chain_zero;
          if (bus.chain_zero) begin
            state_d = DONE;
          end
        end
      end

      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.start && preset_ok) begin
          state_d = LOAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Flags are registered from the next state so
  // they line up with the state they describe and are glitch-free.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      // NOTE: all control registers, including the preset, are reset; there
      // is no storage array here that could be left unreset.
      state_q   <= IDLE;
      presc_q   <= '0;
      preset_q  <= 16'h0000;
      load_n_q  <= 1'b1;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      preset_q  <= preset_d;
      load_n_q  <= (state_d != LOAD);
      running_q <= (state_d == RUN);
      paused_q  <= (state_d == PAUSE);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.preset  = preset_q;
  assign bus.load_n  = load_n_q;
  assign bus.en      = en_c;
  assign bus.running = running_q;
  assign bus.paused  = paused_q;
  assign bus.done    = done_q;

endmodule
